bcd_counter_n: RTL and testbench

BCD_COUNTER_N -- requirements
Module: bcd_counter_n

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bcd_digit.sv | 28 ++
 rtl/bcd_counter_n.sv | 54 +++++
 tb/tb_bcd_counter_n.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit limits and nibble validity check
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;
  function automatic logic is_bcd(input logic [3:0] n);
    return n <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one up/down BCD digit; ports CLK, Reset_n, Tin (advance), Up, Ld, Din -> Dout, Tout (terminal carry/borrow)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       Tin,
  input  logic       Up,
  input  logic       Ld,
  input  logic [3:0] Din,
  output logic [3:0] Dout,
  output logic       Tout
);
  logic [3:0] dout_q, dout_d;
  logic       at_end;
  always_comb begin
    at_end = Up ? (dout_q == BCD_MAX) : (dout_q == BCD_MIN);
    Tout   = Tin & at_end;
    dout_d = Ld      ? Din :
             !Tin    ? dout_q :
             at_end  ? (Up ? BCD_MIN : BCD_MAX) :
             Up      ? dout_q + 4'd1 : dout_q - 4'd1;
  end
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) dout_q <= BCD_MIN;
    else          dout_q <= dout_d;
  assign Dout = dout_q;
endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: DIGITS-digit up/down BCD counter; ports CLK, Reset_n, En, Up, Load, D -> Q, Tc (comb terminal count), Err (rejected-load pulse)
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  Tc,
  output logic                  Err
);
  logic [DIGITS-1:0] carry;
  logic              d_ok, all_max, all_min, term, ld, tin0, err_d, err_q, last_tout_unused;
  always_comb begin
    d_ok    = 1'b1;
    all_max = 1'b1;
    all_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d_ok    = d_ok & is_bcd(D[4*i+:4]);
      all_max = all_max & (Q[4*i+:4] == BCD_MAX);
      all_min = all_min & (Q[4*i+:4] == BCD_MIN);
    end
    term  = Up ? all_max : all_min;
    Tc    = En & ~Load & term;
    ld    = Load & d_ok;
    // saturating build withholds the advance at terminal count so Q holds
    tin0  = En & ~Load & (WRAP | ~term);
    err_d = Load & ~d_ok;
  end
  assign carry[0] = tin0;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i < DIGITS - 1) begin : g_mid
      bcd_digit u_dig (
        .CLK(CLK), .Reset_n(Reset_n), .Tin(carry[i]), .Up(Up), .Ld(ld),
        .Din(D[4*i+:4]), .Dout(Q[4*i+:4]), .Tout(carry[i+1])
      );
    end else begin : g_last
      bcd_digit u_dig (
        .CLK(CLK), .Reset_n(Reset_n), .Tin(carry[i]), .Up(Up), .Ld(ld),
        .Din(D[4*i+:4]), .Dout(Q[4*i+:4]), .Tout(last_tout_unused)
      );
    end
  end
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  assign Err = err_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: directed and random checks of wrapping, saturating, 1-digit and 8-digit counters
module tb_bcd_counter_n;
  logic CLK = 1'b0, Reset_n = 1'b0, En = 1'b0, Up = 1'b0, Load = 1'b0;
  logic [15:0] d4 = '0, d_hi = '0;
  logic [15:0] q4, qs;
  logic [3:0]  q1;
  logic [31:0] q8;
  logic tc4, tcs, tc1, tc8, err4, errs, err1, err8;
  int n_cmp = 0, n_bad = 0;
  longint m4 = 0, ms = 0, m1 = 0, m8 = 0;
  bit e4 = 0;
  logic [31:0] t, ts, t1, t8;

  always #5 CLK = ~CLK;

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) dut (.CLK(CLK), .Reset_n(Reset_n), .En(En), .Up(Up), .Load(Load), .D(d4), .Q(q4), .Tc(tc4), .Err(err4));
  bcd_counter_n #(.DIGITS(4), .WRAP(1'b0)) dut_s (.CLK(CLK), .Reset_n(Reset_n), .En(En), .Up(Up), .Load(Load), .D(d4), .Q(qs), .Tc(tcs), .Err(errs));
  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) dut1 (.CLK(CLK), .Reset_n(Reset_n), .En(En), .Up(Up), .Load(Load), .D(d4[3:0]), .Q(q1), .Tc(tc1), .Err(err1));
  bcd_counter_n #(.DIGITS(8), .WRAP(1'b1)) dut8 (.CLK(CLK), .Reset_n(Reset_n), .En(En), .Up(Up), .Load(Load), .D({d_hi, d4}), .Q(q8), .Tc(tc8), .Err(err8));

  function automatic longint pw(int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic bit valid(logic [31:0] d, int n);
    for (int i = 0; i < n; i++) if (d[4*i+:4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint dec(logic [31:0] d, int n);
    longint v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 10 + longint'(d[4*i+:4]);
    return v;
  endfunction

  function automatic logic [31:0] enc(longint m, int n);
    logic [31:0] r = '0;
    longint v = m;
    for (int i = 0; i < n; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic longint nxt(longint m, int n, bit wrap, logic [31:0] d);
    longint mx = pw(n) - 1;
    if (Load) return valid(d, n) ? dec(d, n) : m;
    if (!En) return m;
    if (Up) return (m == mx) ? (wrap ? 0 : m) : m + 1;
    return (m == 0) ? (wrap ? mx : 0) : m - 1;
  endfunction

  task automatic tick();
    e4 = Load && !valid({16'h0, d4}, 4);
    m4 = nxt(m4, 4, 1'b1, {16'h0, d4});
    ms = nxt(ms, 4, 1'b0, {16'h0, d4});
    m1 = nxt(m1, 1, 1'b1, {28'h0, d4[3:0]});
    m8 = nxt(m8, 8, 1'b1, {d_hi, d4});
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    m4 = 0; ms = 0; m1 = 0; m8 = 0; e4 = 0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; En = 1'b0; Up = 1'b1; Load = 1'b0;
    #3;
    n_cmp++;
    if (q4 !== 16'h0 || err4 !== 1'b0 || qs !== 16'h0 || q1 !== 4'h0 || q8 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset q4=%h err=%b qs=%h q1=%h q8=%h, need all zero", q4, err4, qs, q1, q8);
    end
    @(posedge CLK);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_up_full();
    do_reset();
    En = 1'b1; Up = 1'b1; Load = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      #1;
      t = enc(m4, 4);
      ts = enc(ms, 4);
      n_cmp++;
      if (q4 !== t[15:0] || tc4 !== (m4 == 9999) || qs !== ts[15:0] || tcs !== (ms == 9999)) begin
        n_bad++;
        $display("FAIL up_run k=%0d q=%h tc=%b qs=%h tcs=%b, need q=%h tc=%b qs=%h tcs=%b",
                 k, q4, tc4, qs, tcs, t[15:0], m4 == 9999, ts[15:0], ms == 9999);
      end
      tick();
    end
    n_cmp++;
    if (q4 !== 16'h0000 || qs !== 16'h9999) begin
      n_bad++;
      $display("FAIL up_rollover q=%h qs=%h, need 0000 / 9999", q4, qs);
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    En = 1'b1; Up = 1'b0; Load = 1'b0;
    #1;
    n_cmp++;
    if (tc4 !== 1'b1 || tcs !== 1'b1) begin
      n_bad++;
      $display("FAIL down_tc tc=%b tcs=%b, need 1 1", tc4, tcs);
    end
    tick();
    n_cmp++;
    if (q4 !== 16'h9999 || qs !== 16'h0000 || tcs !== 1'b1) begin
      n_bad++;
      $display("FAIL down_wrap q=%h qs=%h tcs=%b, need 9999 0000 1", q4, qs, tcs);
    end
    En = 1'b0;
  endtask

  task automatic test_load_err();
    Load = 1'b1; d4 = 16'h12A4;
    tick();
    n_cmp++;
    if (q4 !== 16'h9999 || err4 !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_load q=%h err=%b, need 9999 1", q4, err4);
    end
    Load = 1'b0;
    tick();
    n_cmp++;
    if (q4 !== 16'h9999 || err4 !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse q=%h err=%b, need 9999 0", q4, err4);
    end
    Load = 1'b1; d4 = 16'h0599;
    tick();
    n_cmp++;
    if (q4 !== 16'h0599 || err4 !== 1'b0) begin
      n_bad++;
      $display("FAIL good_load q=%h err=%b, need 0599 0", q4, err4);
    end
    Load = 1'b0;
  endtask

  task automatic test_load_priority();
    Load = 1'b1; d4 = 16'h0199; En = 1'b0;
    tick();
    En = 1'b1; Up = 1'b1; d4 = 16'h0042;
    #1;
    n_cmp++;
    if (tc4 !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_tc tc=%b, need 0", tc4);
    end
    tick();
    n_cmp++;
    if (q4 !== 16'h0042) begin
      n_bad++;
      $display("FAIL prio_load q=%h, need 0042", q4);
    end
    d4 = 16'h9999; En = 1'b0;
    tick();
    En = 1'b1;
    #1;
    n_cmp++;
    if (tc4 !== 1'b0) begin
      n_bad++;
      $display("FAIL load_masks_tc tc=%b, need 0", tc4);
    end
    Load = 1'b0;
    #1;
    n_cmp++;
    if (tc4 !== 1'b1) begin
      n_bad++;
      $display("FAIL tc_at_9999 tc=%b, need 1", tc4);
    end
    En = 1'b0;
  endtask

  task automatic test_async_reset();
    Load = 1'b1; d4 = 16'h0999; En = 1'b0;
    tick();
    Load = 1'b0; En = 1'b1; Up = 1'b1;
    #2;
    Reset_n = 1'b0;
    #1;
    n_cmp++;
    if (q4 !== 16'h0000 || err4 !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset q=%h err=%b, need 0000 0", q4, err4);
    end
    Reset_n = 1'b1;
    m4 = 0; ms = 0; m1 = 0; m8 = 0; e4 = 0;
    tick();
    n_cmp++;
    if (q4 !== 16'h0001) begin
      n_bad++;
      $display("FAIL after_reset q=%h, need 0001", q4);
    end
    En = 1'b0;
  endtask

  task automatic test_small_big();
    do_reset();
    En = 1'b1; Up = 1'b1; Load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (q1 !== 4'(k % 10)) begin
        n_bad++;
        $display("FAIL d1_up k=%0d q1=%h, need %0d", k, q1, k % 10);
      end
    end
    Up = 1'b0;
    tick();
    n_cmp++;
    if (q1 !== 4'h9) begin
      n_bad++;
      $display("FAIL d1_down q1=%h, need 9", q1);
    end
    En = 1'b0; Load = 1'b1; d_hi = 16'h9999; d4 = 16'h9999;
    tick();
    n_cmp++;
    if (q8 !== 32'h99999999) begin
      n_bad++;
      $display("FAIL d8_load q8=%h, need 99999999", q8);
    end
    Load = 1'b0; En = 1'b1; Up = 1'b1;
    #1;
    n_cmp++;
    if (tc8 !== 1'b1) begin
      n_bad++;
      $display("FAIL d8_tc tc=%b, need 1", tc8);
    end
    tick();
    n_cmp++;
    if (q8 !== 32'h00000000) begin
      n_bad++;
      $display("FAIL d8_up_wrap q8=%h, need 00000000", q8);
    end
    Up = 1'b0;
    tick();
    n_cmp++;
    if (q8 !== 32'h99999999) begin
      n_bad++;
      $display("FAIL d8_down_wrap q8=%h, need 99999999", q8);
    end
    En = 1'b0; d_hi = '0;
  endtask

  task automatic test_random();
    logic [31:0] r;
    bit exp_tc;
    for (int k = 0; k < 400; k++) begin
      En = 1'($urandom_range(0, 3) != 0);
      Up = 1'($urandom_range(0, 1));
      Load = 1'($urandom_range(0, 9) == 0);
      r = enc(longint'($urandom_range(0, 9999)), 4);
      d4 = ($urandom_range(0, 4) == 0) ? 16'($urandom) : r[15:0];
      r = enc(longint'($urandom_range(0, 9999)), 4);
      d_hi = r[15:0];
      #1;
      exp_tc = En && !Load && (Up ? (m4 == 9999) : (m4 == 0));
      n_cmp++;
      if (tc4 !== exp_tc) begin
        n_bad++;
        $display("FAIL rand_tc k=%0d tc=%b, need %b", k, tc4, exp_tc);
      end
      tick();
      t = enc(m4, 4); ts = enc(ms, 4); t1 = enc(m1, 1); t8 = enc(m8, 8);
      n_cmp++;
      if (q4 !== t[15:0] || qs !== ts[15:0] || q1 !== t1[3:0] || q8 !== t8 || err4 !== e4) begin
        n_bad++;
        $display("FAIL rand_q k=%0d q4=%h qs=%h q1=%h q8=%h err=%b, need %h %h %h %h %b",
                 k, q4, qs, q1, q8, err4, t[15:0], ts[15:0], t1[3:0], t8, e4);
      end
    end
    En = 1'b0; Load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_full();
    test_down_wrap();
    test_load_err();
    test_load_priority();
    test_async_reset();
    test_small_big();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
